// File: rtl/store_write_buffer.sv
// Store write buffer: aligns stores into 64-bit lanes with a byte strobe, queues them
// in a small FIFO and drains them to the data-memory write port. Supports flush and hazard lookup.
module store_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              st_valid_i,
  output logic              st_ready_o,
  input  logic [ADDR_W-1:0] st_addr_i,
  input  logic [63:0]       st_data_i,
  input  logic [1:0]        st_size_i,
  output logic              mem_wvalid_o,
  input  logic              mem_wready_i,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output logic [63:0]       mem_wdata_o,
  output logic [7:0]        mem_wmask_o,
  input  logic [ADDR_W-1:0] ld_addr_i,
  output logic              ld_hazard_o,
  input  logic              flush_req_i,
  output logic              flush_done_o,
  output logic              misalign_err_o,
  output logic [CW-1:0]     count_o
);

  // state | meaning
  // IDLE  | accepting stores
  // DRAIN | flush in progress, stores blocked until the FIFO empties
  // DONE  | flush complete, flush_done pulses for this cycle
  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              misalign_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [63:0]       data_q [DEPTH];
  logic [7:0]        mask_q [DEPTH];

  logic [2:0]  off;
  logic [7:0]  lane_mask, st_mask;
  logic [63:0] data_lo, st_wdata;
  logic        misalign, push, push_wr, pop;

  always_comb begin
    off = st_addr_i[2:0];
    case (st_size_i)
      2'd0: begin
        lane_mask = 8'h01;
        data_lo   = {56'b0, st_data_i[7:0]};
        misalign  = 1'b0;
      end
      2'd1: begin
        lane_mask = 8'h03;
        data_lo   = {48'b0, st_data_i[15:0]};
        misalign  = off[0];
      end
      2'd2: begin
        lane_mask = 8'h0F;
        data_lo   = {32'b0, st_data_i[31:0]};
        misalign  = |off[1:0];
      end
      default: begin
        lane_mask = 8'hFF;
        data_lo   = st_data_i;
        misalign  = |off;
      end
    endcase
    st_mask  = lane_mask << off;
    st_wdata = data_lo << {off, 3'b000};
  end

  assign push    = st_valid_i && st_ready_o;
  assign push_wr = push && !misalign;
  assign pop     = mem_wvalid_o && mem_wready_i;

  always_comb begin
    wr_ptr_d = push_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push_wr, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      misalign_q <= push && misalign;
    end
  end

  // Payload storage needs no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push_wr) begin
      addr_q[wr_ptr_q] <= {st_addr_i[ADDR_W-1:3], 3'b000};
      data_q[wr_ptr_q] <= st_wdata;
      mask_q[wr_ptr_q] <= st_mask;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (flush_req_i) state_d = (count_q == '0 && !push_wr) ? S_DONE : S_DRAIN;
      S_DRAIN: if (count_q == '0) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    st_ready_o   = (count_q != CW'(DEPTH)) && (state_q == S_IDLE);
    flush_done_o = (state_q == S_DONE);
  end

  assign mem_wvalid_o   = (count_q != '0);
  assign mem_waddr_o    = addr_q[rd_ptr_q];
  assign mem_wdata_o    = data_q[rd_ptr_q];
  assign mem_wmask_o    = mask_q[rd_ptr_q];
  assign misalign_err_o = misalign_q;
  assign count_o        = count_q;

  // The head is excluded while it is leaving, since that store is already committed.
  logic [PW-1:0] idx;
  always_comb begin
    idx         = rd_ptr_q;
    ld_hazard_o = push_wr && (st_addr_i[ADDR_W-1:3] == ld_addr_i[ADDR_W-1:3]);
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if ((CW'(k) < count_q) && !(k == 0 && pop) &&
          (addr_q[idx][ADDR_W-1:3] == ld_addr_i[ADDR_W-1:3]))
        ld_hazard_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer: a scoreboard queue of expected memory writes is
// filled as stores are accepted and checked by a forked monitor on the falling edge.
module tb_store_write_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        st_valid, st_ready;
  logic [63:0] st_addr, st_data;
  logic [1:0]  st_size;
  logic        mem_wvalid, mem_wready;
  logic [63:0] mem_waddr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic [63:0] ld_addr;
  logic        ld_hazard, flush_req, flush_done, misalign_err;
  logic [2:0]  count;

  store_write_buffer #(.DEPTH(4), .ADDR_W(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .st_valid_i(st_valid), .st_ready_o(st_ready),
    .st_addr_i(st_addr), .st_data_i(st_data), .st_size_i(st_size),
    .mem_wvalid_o(mem_wvalid), .mem_wready_i(mem_wready),
    .mem_waddr_o(mem_waddr), .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask),
    .ld_addr_i(ld_addr), .ld_hazard_o(ld_hazard),
    .flush_req_i(flush_req), .flush_done_o(flush_done),
    .misalign_err_o(misalign_err), .count_o(count)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] a;
    logic [63:0] d;
    logic [7:0]  m;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  logic         hold_q;
  logic [135:0] prev_head;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Holds st_valid until the buffer is ready; ok=0 marks a store that must never reach memory.
  task automatic push(input logic [63:0] a, input logic [63:0] d, input logic [1:0] sz,
                      input bit ok, input logic [63:0] ea, input logic [63:0] ed,
                      input logic [7:0] em);
    int n;
    exp_t e;
    n = 0;
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_size  = sz;
    @(negedge clk_i);
    while (!st_ready && n < 50) begin
      n++;
      @(negedge clk_i);
    end
    if (!st_ready) begin
      n_vec++;
      n_miss++;
      $display("FAIL push_timeout: st_ready stayed 0 for addr 0x%0h", a);
      st_valid = 1'b0;
    end else if (ok) begin
      e.a = ea;
      e.d = ed;
      e.m = em;
      exp_q.push_back(e);
    end
    @(posedge clk_i);
    #1;
    st_valid = 1'b0;
  endtask

  initial begin
    int pulses;
    int ready_viol;
    rst_ni = 1'b0;
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0;
    mem_wready = 1'b0; ld_addr = '0; flush_req = 1'b0;
    hold_q = 1'b0; prev_head = '0;

    fork
      forever begin
        exp_t e;
        @(negedge clk_i);
        if (!rst_ni) begin
          hold_q = 1'b0;
        end else begin
          if (hold_q && mem_wvalid) begin
            n_vec++;
            if ({mem_waddr, mem_wdata, mem_wmask} !== prev_head) begin
              n_miss++;
              $display("FAIL head_hold: got 0x%0h expected 0x%0h",
                       {mem_waddr, mem_wdata, mem_wmask}, prev_head);
            end
          end
          hold_q    = mem_wvalid && !mem_wready;
          prev_head = {mem_waddr, mem_wdata, mem_wmask};
          if (mem_wvalid && mem_wready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
              n_miss++;
              $display("FAIL mem_write_unexpected: got addr 0x%0h data 0x%0h mask 0x%0h, expected none",
                       mem_waddr, mem_wdata, mem_wmask);
            end else begin
              e = exp_q.pop_front();
              if (mem_waddr !== e.a || mem_wdata !== e.d || mem_wmask !== e.m) begin
                n_miss++;
                $display("FAIL mem_write: got addr 0x%0h data 0x%0h mask 0x%0h expected addr 0x%0h data 0x%0h mask 0x%0h",
                         mem_waddr, mem_wdata, mem_wmask, e.a, e.d, e.m);
              end
            end
          end
        end
      end
    join_none

    // Reset state
    #12;
    chk("rst_count", 64'(count), 0);
    chk("rst_wvalid", 64'(mem_wvalid), 0);
    chk("rst_flush_done", 64'(flush_done), 0);
    chk("rst_misalign", 64'(misalign_err), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    chk("idle_st_ready", 64'(st_ready), 1);

    // 1: byte store, next-cycle visibility
    mem_wready = 1'b1;
    push(64'h1003, 64'hAB, 2'd0, 1, 64'h1000, 64'h0000_0000_AB00_0000, 8'h08);
    chk("t1_wvalid_next", 64'(mem_wvalid), 1);
    chk("t1_count", 64'(count), 1);
    tick();
    tick();
    chk("t1_drained", 64'(count), 0);

    // 2: dword and half stores, upper garbage bits masked off
    push(64'h2000, 64'h1122_3344_5566_7788, 2'd3, 1, 64'h2000, 64'h1122_3344_5566_7788, 8'hFF);
    push(64'h2006, 64'hFFFF_0000_1234_BEEF, 2'd1, 1, 64'h2000, 64'hBEEF_0000_0000_0000, 8'hC0);
    tick();
    tick();

    // 3: fill while memory stalls, then drain with concurrent pushes
    mem_wready = 1'b0;
    push(64'h5000, 64'hA0, 2'd3, 1, 64'h5000, 64'hA0, 8'hFF);
    push(64'h5008, 64'hA1, 2'd3, 1, 64'h5008, 64'hA1, 8'hFF);
    push(64'h5010, 64'hA2, 2'd3, 1, 64'h5010, 64'hA2, 8'hFF);
    push(64'h5018, 64'hA3, 2'd3, 1, 64'h5018, 64'hA3, 8'hFF);
    chk("t3_full_count", 64'(count), 4);
    chk("t3_full_ready", 64'(st_ready), 0);
    tick();
    tick();
    tick();
    mem_wready = 1'b1;
    push(64'h5020, 64'hA4, 2'd3, 1, 64'h5020, 64'hA4, 8'hFF);
    chk("t3_pushpop_count", 64'(count), 3);
    push(64'h5028, 64'hA5, 2'd3, 1, 64'h5028, 64'hA5, 8'hFF);
    chk("t3_pushpop_count2", 64'(count), 3);
    tick();
    tick();
    tick();
    chk("t3_drained", 64'(count), 0);

    // 4: misaligned word store is dropped
    push(64'h3002, 64'h1122_3344, 2'd2, 0, 64'h0, 64'h0, 8'h0);
    chk("t4_misalign_pulse", 64'(misalign_err), 1);
    chk("t4_count", 64'(count), 0);
    tick();
    chk("t4_misalign_clear", 64'(misalign_err), 0);

    // 5: load/store hazard
    mem_wready = 1'b0;
    push(64'h4010, 64'hD0, 2'd3, 1, 64'h4010, 64'hD0, 8'hFF);
    ld_addr = 64'h4014;
    #1 chk("t5_hazard_same_word", 64'(ld_hazard), 1);
    ld_addr = 64'h4018;
    #1 chk("t5_hazard_next_word", 64'(ld_hazard), 0);
    st_valid = 1'b1; st_addr = 64'h4018; st_data = 64'hD1; st_size = 2'd3;
    #1 chk("t5_hazard_inflight_push", 64'(ld_hazard), 1);
    push(64'h4018, 64'hD1, 2'd3, 1, 64'h4018, 64'hD1, 8'hFF);
    ld_addr = 64'h4010;
    #1 chk("t5_hazard_head", 64'(ld_hazard), 1);
    mem_wready = 1'b1;
    #1 chk("t5_hazard_head_popping", 64'(ld_hazard), 0);
    ld_addr = 64'h4018;
    #1 chk("t5_hazard_second", 64'(ld_hazard), 1);
    tick();
    tick();
    chk("t5_drained", 64'(count), 0);

    // 6: flush with toggling wready
    mem_wready = 1'b0;
    push(64'h6000, 64'hE0, 2'd3, 1, 64'h6000, 64'hE0, 8'hFF);
    push(64'h6008, 64'hE1, 2'd3, 1, 64'h6008, 64'hE1, 8'hFF);
    push(64'h6010, 64'hE2, 2'd3, 1, 64'h6010, 64'hE2, 8'hFF);
    flush_req = 1'b1;
    tick();
    chk("t6_drain_ready", 64'(st_ready), 0);
    pulses = 0;
    ready_viol = 0;
    for (int i = 0; i < 40; i++) begin
      mem_wready = ~mem_wready;
      tick();
      if (flush_done) begin
        pulses++;
        chk("t6_done_count", 64'(count), 0);
        flush_req = 1'b0;
      end else if (pulses == 0 && st_ready) begin
        ready_viol++;
      end
    end
    chk("t6_flush_pulses", 64'(pulses), 1);
    chk("t6_ready_during_drain", 64'(ready_viol), 0);
    mem_wready = 1'b1;

    // Flush on an empty FIFO completes on the first edge
    flush_req = 1'b1;
    tick();
    chk("t6_empty_flush_done", 64'(flush_done), 1);
    flush_req = 1'b0;
    tick();
    chk("t6_empty_flush_clear", 64'(flush_done), 0);

    // Reset asserted mid-drain
    mem_wready = 1'b0;
    push(64'h7000, 64'hF0, 2'd3, 1, 64'h7000, 64'hF0, 8'hFF);
    push(64'h7008, 64'hF1, 2'd3, 1, 64'h7008, 64'hF1, 8'hFF);
    push(64'h7010, 64'hF2, 2'd3, 1, 64'h7010, 64'hF2, 8'hFF);
    flush_req = 1'b1;
    mem_wready = 1'b1;
    tick();
    #2;
    rst_ni = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_rst_wvalid", 64'(mem_wvalid), 0);
    chk("t6_rst_count", 64'(count), 0);
    flush_req = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    chk("t6_post_rst_ready", 64'(st_ready), 1);
    chk("t6_post_rst_done", 64'(flush_done), 0);

    tick();
    tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
